// File: rtl/lane_receiver_if.sv
// Lane receiver bus: decoded character stream in, lock/idle/payload indications out.
interface lane_receiver_if;
  logic [7:0] data_in;
  logic       ctrl_in;
  logic       valid_in;
  logic       code_err;
  logic       lane_up;
  logic       rx_k;
  logic       rx_a;
  logic       rx_r;
  logic [7:0] data_out;
  logic       data_valid;
  logic       sof;
  logic       eof;
  logic       frame_err;

  // Upstream decoder side: drives characters, observes results.
  modport master (
    output data_in, ctrl_in, valid_in, code_err,
    input  lane_up, rx_k, rx_a, rx_r, data_out, data_valid, sof, eof, frame_err
  );

  // Receiver side.
  modport slave (
    input  data_in, ctrl_in, valid_in, code_err,
    output lane_up, rx_k, rx_a, rx_r, data_out, data_valid, sof, eof, frame_err
  );
endinterface

// File: rtl/lane_receiver.sv
// Per-lane receiver: idle ordered-set detection, lane lock tracking and SCP/ECP deframing.
// Payload bytes pass through a one-byte hold register so the last byte can be tagged with eof.
module lane_receiver #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_LIMIT  = 4,
  parameter int unsigned GOOD_RUN   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  lane_receiver_if.slave bus
);

  localparam int unsigned CW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned EW = $clog2(ERR_LIMIT + 1);
  localparam int unsigned GW = $clog2(GOOD_RUN + 1);
  localparam logic [CW-1:0] CommaMax = CW'(LOCK_COUNT);
  localparam logic [EW-1:0] ErrMax   = EW'(ERR_LIMIT);
  localparam logic [GW-1:0] GoodMax  = GW'(GOOD_RUN);

  localparam logic [7:0] KComma = 8'hBC;
  localparam logic [7:0] KAlign = 8'h7C;
  localparam logic [7:0] KRdy   = 8'h1C;
  localparam logic [7:0] KScp1  = 8'h5C;
  localparam logic [7:0] KScp2  = 8'hFB;
  localparam logic [7:0] KEcp1  = 8'hFD;
  localparam logic [7:0] KEcp2  = 8'hFE;

  typedef enum logic [1:0] {LaneDown, LaneAlign, LaneUp} lane_state_e;
  typedef enum logic [1:0] {FrameIdle, FrameScp, FrameData, FrameEcp} frame_state_e;

  lane_state_e  lane_q;
  frame_state_e frame_q;
  logic [CW-1:0] comma_cnt_q, comma_inc;
  logic [EW-1:0] err_cnt_q, err_inc;
  logic [GW-1:0] good_cnt_q, good_inc;
  logic [7:0]    hold_q, data_out_q;
  logic          hold_full_q, first_pending_q;
  logic          lane_up_q, rx_k_q, rx_a_q, rx_r_q;
  logic          data_valid_q, sof_q, eof_q, frame_err_q;

  logic beat, err_beat, is_k, is_data, k_comma, k_align, k_rdy, k_idle, lane_drop;

  // Beat classification and saturating counter increments.
  always_comb begin
    beat      = bus.valid_in;
    err_beat  = bus.valid_in & bus.code_err;
    is_k      = bus.valid_in & ~bus.code_err & bus.ctrl_in;
    is_data   = bus.valid_in & ~bus.code_err & ~bus.ctrl_in;
    k_comma   = is_k && (bus.data_in == KComma);
    k_align   = is_k && (bus.data_in == KAlign);
    k_rdy     = is_k && (bus.data_in == KRdy);
    k_idle    = k_comma | k_align | k_rdy;
    comma_inc = (comma_cnt_q == CommaMax) ? comma_cnt_q : comma_cnt_q + CW'(1);
    err_inc   = (err_cnt_q == ErrMax) ? err_cnt_q : err_cnt_q + EW'(1);
    good_inc  = (good_cnt_q == GoodMax) ? good_cnt_q : good_cnt_q + GW'(1);
    lane_drop = (lane_q == LaneUp) && err_beat && (err_inc == ErrMax);
  end

  // Lane lock FSM plus idle-character pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q      <= LaneDown;
      lane_up_q   <= 1'b0;
      comma_cnt_q <= '0;
      err_cnt_q   <= '0;
      good_cnt_q  <= '0;
      rx_k_q      <= 1'b0;
      rx_a_q      <= 1'b0;
      rx_r_q      <= 1'b0;
    end else begin
      rx_k_q <= k_comma;
      rx_a_q <= k_align;
      rx_r_q <= k_rdy;
      if (beat) begin
        unique case (lane_q)
          LaneDown: begin
            if (k_comma) begin
              err_cnt_q  <= '0;
              good_cnt_q <= '0;
              if (CommaMax <= CW'(1)) begin
                lane_q      <= LaneUp;
                lane_up_q   <= 1'b1;
                comma_cnt_q <= '0;
              end else begin
                lane_q      <= LaneAlign;
                comma_cnt_q <= CW'(1);
              end
            end
          end
          LaneAlign: begin
            if (err_beat) begin
              lane_q      <= LaneDown;
              comma_cnt_q <= '0;
            end else if (k_comma) begin
              if (comma_inc == CommaMax) begin
                lane_q      <= LaneUp;
                lane_up_q   <= 1'b1;
                comma_cnt_q <= '0;
                err_cnt_q   <= '0;
                good_cnt_q  <= '0;
              end else begin
                comma_cnt_q <= comma_inc;
              end
            end
          end
          LaneUp: begin
            if (err_beat) begin
              good_cnt_q <= '0;
              if (lane_drop) begin
                lane_q    <= LaneDown;
                lane_up_q <= 1'b0;
                err_cnt_q <= '0;
              end else begin
                err_cnt_q <= err_inc;
              end
            end else if (good_inc == GoodMax) begin
              err_cnt_q  <= '0;
              good_cnt_q <= '0;
            end else begin
              good_cnt_q <= good_inc;
            end
          end
          default: lane_q <= LaneDown;
        endcase
      end
    end
  end

  // Frame FSM: strips SCP/ECP, delays payload by one byte to mark sof/eof.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q         <= FrameIdle;
      hold_q          <= '0;
      hold_full_q     <= 1'b0;
      first_pending_q <= 1'b0;
      data_out_q      <= '0;
      data_valid_q    <= 1'b0;
      sof_q           <= 1'b0;
      eof_q           <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_err_q  <= 1'b0;
      if (lane_drop || (lane_q != LaneUp)) begin
        // Losing the lane mid-frame aborts the frame without an eof.
        frame_err_q     <= lane_drop && (frame_q != FrameIdle);
        frame_q         <= FrameIdle;
        hold_full_q     <= 1'b0;
        first_pending_q <= 1'b0;
      end else if (beat) begin
        unique case (frame_q)
          FrameIdle: begin
            if (is_data) begin
              frame_err_q <= 1'b1;
            end else if (is_k && (bus.data_in == KScp1)) begin
              frame_q <= FrameScp;
            end
          end
          FrameScp: begin
            if (is_k && (bus.data_in == KScp2)) begin
              frame_q         <= FrameData;
              first_pending_q <= 1'b1;
              hold_full_q     <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              frame_q     <= FrameIdle;
            end
          end
          FrameData: begin
            if (is_data) begin
              if (hold_full_q) begin
                data_out_q      <= hold_q;
                data_valid_q    <= 1'b1;
                sof_q           <= first_pending_q;
                first_pending_q <= 1'b0;
              end
              hold_q      <= bus.data_in;
              hold_full_q <= 1'b1;
            end else if (is_k && !k_idle) begin
              if (bus.data_in == KEcp1) begin
                frame_q <= FrameEcp;
              end else begin
                frame_err_q <= 1'b1;
                hold_full_q <= 1'b0;
                frame_q     <= (bus.data_in == KScp1) ? FrameScp : FrameIdle;
              end
            end
          end
          FrameEcp: begin
            if (is_k && (bus.data_in == KEcp2) && hold_full_q) begin
              data_out_q   <= hold_q;
              data_valid_q <= 1'b1;
              sof_q        <= first_pending_q;
              eof_q        <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            hold_full_q     <= 1'b0;
            first_pending_q <= 1'b0;
            frame_q         <= FrameIdle;
          end
          default: frame_q <= FrameIdle;
        endcase
      end
    end
  end

  assign bus.lane_up    = lane_up_q;
  assign bus.rx_k       = rx_k_q;
  assign bus.rx_a       = rx_a_q;
  assign bus.rx_r       = rx_r_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.sof        = sof_q;
  assign bus.eof        = eof_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_lane_receiver.sv
// Bench for lane_receiver: table of beats with expected outputs, checked through a scoreboard.
module tb_lane_receiver;

  localparam int KCH = 0;  // clean K character
  localparam int DCH = 1;  // clean data character
  localparam int ERR = 2;  // code_err beat (ctrl_in=1)
  localparam int IDL = 3;  // valid_in=0 cycle (ctrl_in=1)

  // Expected flag bits: {lane_up, rx_k, rx_a, rx_r, data_valid, sof, eof, frame_err}
  localparam logic [7:0] UP = 8'h80, KP = 8'h40, AP = 8'h20, RP = 8'h10;
  localparam logic [7:0] DV = 8'h08, SF = 8'h04, EF = 8'h02, FE = 8'h01;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] d;
    logic [7:0] flags;
    logic [7:0] dout;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] flags;
    logic [7:0] dout;
    int         tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  exp_t sb[$];
  exp_t cur;

  lane_receiver_if bus();

  lane_receiver #(
    .LOCK_COUNT(4),
    .ERR_LIMIT (4),
    .GOOD_RUN  (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic vec_t mk(string n, int kind, logic [7:0] d, logic [7:0] f,
                              logic [7:0] o = 8'h00);
    vec_t v;
    v.name = n; v.kind = kind; v.d = d; v.flags = f; v.dout = o;
    return v;
  endfunction

  task automatic check(string name, logic [7:0] ef, logic [7:0] ed);
    logic [7:0] af, ad, edm;
    af  = {bus.lane_up, bus.rx_k, bus.rx_a, bus.rx_r,
           bus.data_valid, bus.sof, bus.eof, bus.frame_err};
    ad  = ef[3] ? bus.data_out : 8'h00;
    edm = ef[3] ? ed : 8'h00;
    n_cmp++;
    if (af !== ef || ad !== edm) begin
      n_fail++;
      $display("FAIL %s: got flags=%b data=%h, want flags=%b data=%h", name, af, ad, ef, edm);
    end
  endtask

  // Beats are captured at the posedge after they are driven; compare on the following negedge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag < cyc) begin
      cur = sb.pop_front();
      check(cur.name, cur.flags, cur.dout);
    end
  end

  task automatic drive(input vec_t t);
    @(posedge clk);
    #1;
    bus.valid_in = (t.kind != IDL);
    bus.ctrl_in  = (t.kind != DCH);
    bus.code_err = (t.kind == ERR);
    bus.data_in  = t.d;
    sb.push_back('{name: t.name, flags: t.flags, dout: t.dout, tag: cyc});
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic relock();
    for (int i = 1; i <= 3; i++) drive(mk($sformatf("relock_bc%0d", i), KCH, 8'hBC, KP));
    drive(mk("relock_bc4", KCH, 8'hBC, UP | KP));
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.ctrl_in  = 1'b0;
    bus.code_err = 1'b0;
    bus.data_in  = 8'h00;
    #3;
    check("reset_state", 8'h00, 8'h00);
    #9;
    rst_n = 1'b1;

    // Lock acquisition, gating, idle detection and the main framing cases.
    tbl.push_back(mk("lock_bc1", KCH, 8'hBC, KP));
    tbl.push_back(mk("lock_bc2", KCH, 8'hBC, KP));
    tbl.push_back(mk("lock_err", ERR, 8'hBC, 8'h00));
    tbl.push_back(mk("lock2_bc1", KCH, 8'hBC, KP));
    tbl.push_back(mk("lock2_bc2", KCH, 8'hBC, KP));
    tbl.push_back(mk("lock2_bc3", KCH, 8'hBC, KP));
    tbl.push_back(mk("gap_invalid", IDL, 8'hBC, 8'h00));
    tbl.push_back(mk("lock2_bc4", KCH, 8'hBC, UP | KP));
    tbl.push_back(mk("idle_a", KCH, 8'h7C, UP | AP));
    tbl.push_back(mk("idle_r", KCH, 8'h1C, UP | RP));
    tbl.push_back(mk("data_in_idle", DCH, 8'h55, UP | FE));
    tbl.push_back(mk("f1_scp", KCH, 8'h5C, UP));
    tbl.push_back(mk("f1_fb", KCH, 8'hFB, UP));
    tbl.push_back(mk("f1_11", DCH, 8'h11, UP));
    tbl.push_back(mk("f1_22", DCH, 8'h22, UP | DV | SF, 8'h11));
    tbl.push_back(mk("f1_33", DCH, 8'h33, UP | DV, 8'h22));
    tbl.push_back(mk("f1_fd", KCH, 8'hFD, UP));
    tbl.push_back(mk("f1_fe", KCH, 8'hFE, UP | DV | EF, 8'h33));
    tbl.push_back(mk("one_scp", KCH, 8'h5C, UP));
    tbl.push_back(mk("one_fb", KCH, 8'hFB, UP));
    tbl.push_back(mk("one_aa", DCH, 8'hAA, UP));
    tbl.push_back(mk("one_fd", KCH, 8'hFD, UP));
    tbl.push_back(mk("one_fe", KCH, 8'hFE, UP | DV | SF | EF, 8'hAA));
    tbl.push_back(mk("ins_scp", KCH, 8'h5C, UP));
    tbl.push_back(mk("ins_fb", KCH, 8'hFB, UP));
    tbl.push_back(mk("ins_11", DCH, 8'h11, UP));
    tbl.push_back(mk("ins_bc", KCH, 8'hBC, UP | KP));
    tbl.push_back(mk("ins_1c", KCH, 8'h1C, UP | RP));
    tbl.push_back(mk("ins_22", DCH, 8'h22, UP | DV | SF, 8'h11));
    tbl.push_back(mk("ins_fd", KCH, 8'hFD, UP));
    tbl.push_back(mk("ins_fe", KCH, 8'hFE, UP | DV | EF, 8'h22));
    tbl.push_back(mk("empty_scp", KCH, 8'h5C, UP));
    tbl.push_back(mk("empty_fb", KCH, 8'hFB, UP));
    tbl.push_back(mk("empty_fd", KCH, 8'hFD, UP));
    tbl.push_back(mk("empty_fe", KCH, 8'hFE, UP | FE));
    tbl.push_back(mk("badscp_5c", KCH, 8'h5C, UP));
    tbl.push_back(mk("badscp_00", DCH, 8'h00, UP | FE));
    tbl.push_back(mk("idle_data55", DCH, 8'h55, UP | FE));
    tbl.push_back(mk("rescp_5c", KCH, 8'h5C, UP));
    tbl.push_back(mk("rescp_fb", KCH, 8'hFB, UP));
    tbl.push_back(mk("rescp_01", DCH, 8'h01, UP));
    tbl.push_back(mk("rescp_5c2", KCH, 8'h5C, UP | FE));
    tbl.push_back(mk("rescp_fb2", KCH, 8'hFB, UP));
    tbl.push_back(mk("rescp_02", DCH, 8'h02, UP));
    tbl.push_back(mk("rescp_fd", KCH, 8'hFD, UP));
    tbl.push_back(mk("rescp_fe", KCH, 8'hFE, UP | DV | SF | EF, 8'h02));
    tbl.push_back(mk("badk_5c", KCH, 8'h5C, UP));
    tbl.push_back(mk("badk_fb", KCH, 8'hFB, UP));
    tbl.push_back(mk("badk_03", DCH, 8'h03, UP));
    tbl.push_back(mk("badk_f7", KCH, 8'hF7, UP | FE));
    tbl.push_back(mk("badk_fe_idle", KCH, 8'hFE, UP));
    tbl.push_back(mk("tbl_quiet", IDL, 8'h00, UP));
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    // Error counter is cleared by a full good run between error bursts.
    for (int i = 0; i < 3; i++) drive(mk($sformatf("burst1_err%0d", i), ERR, 8'h00, UP));
    for (int i = 0; i < 16; i++) drive(mk($sformatf("good1_%0d", i), KCH, 8'h7C, UP | AP));
    for (int i = 0; i < 3; i++) drive(mk($sformatf("burst2_err%0d", i), ERR, 8'h00, UP));
    for (int i = 0; i < 16; i++) drive(mk($sformatf("good2_%0d", i), KCH, 8'h7C, UP | AP));

    // Lane drop mid-frame: frame_err, no eof, frame discarded.
    drive(mk("drop_scp", KCH, 8'h5C, UP));
    drive(mk("drop_fb", KCH, 8'hFB, UP));
    drive(mk("drop_11", DCH, 8'h11, UP));
    drive(mk("drop_22", DCH, 8'h22, UP | DV | SF, 8'h11));
    drive(mk("drop_err1", ERR, 8'h00, UP));
    drive(mk("drop_33", DCH, 8'h33, UP | DV, 8'h22));
    drive(mk("drop_err2", ERR, 8'h00, UP));
    drive(mk("drop_err3", ERR, 8'h00, UP));
    drive(mk("drop_err4", ERR, 8'h00, FE));
    drive(mk("drop_fd", KCH, 8'hFD, 8'h00));
    drive(mk("drop_fe", KCH, 8'hFE, 8'h00));
    drive(mk("drop_quiet", IDL, 8'h00, 8'h00));

    // One clean beat short of a good run does not clear the error count.
    relock();
    for (int i = 0; i < 3; i++) drive(mk($sformatf("short_err%0d", i), ERR, 8'h00, UP));
    for (int i = 0; i < 15; i++) drive(mk($sformatf("short_good%0d", i), KCH, 8'h7C, UP | AP));
    drive(mk("short_err_last", ERR, 8'h00, 8'h00));
    drive(mk("short_quiet", IDL, 8'h00, 8'h00));

    // Asynchronous reset mid-frame with the lane up.
    relock();
    drive(mk("rst_scp", KCH, 8'h5C, UP));
    drive(mk("rst_fb", KCH, 8'hFB, UP));
    drive(mk("rst_11", DCH, 8'h11, UP));
    drive(mk("rst_22", DCH, 8'h22, UP | DV | SF, 8'h11));
    drive(mk("rst_quiet", IDL, 8'h00, UP));
    drain();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 8'h00, 8'h00);
    #3;
    rst_n = 1'b1;
    drive(mk("post_rst_bc", KCH, 8'hBC, KP));
    drive(mk("post_rst_quiet", IDL, 8'h00, 8'h00));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
